// File: rtl/cmp_share_arbiter_pkg.sv
// Shared constants and FSM encoding for the comparator-sharing arbiter.
package cmp_share_arbiter_pkg;

    localparam int CMP_WIDTH = 5;
    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESPOND = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_share_arbiter_neq_cmp.sv
// Combinational inequality test: high when any bit position of a and b differs.
module neq_cmp
    import cmp_share_arbiter_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             neq
);

    assign neq = |(a ^ b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one neq_cmp among four requesters.
// state   | meaning
// IDLE    | waiting for a request; grants the round-robin winner combinationally
// COMPARE | operands registered; shared comparator result captured
// RESPOND | result presented on the response port until rsp_ready
module cmp_share_arbiter
    import cmp_share_arbiter_pkg::*;
#(
    parameter int N_REQ = NUM_REQ,
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_neq,
    input  logic                   rsp_ready,
    output logic                   busy
);

    state_t            state, next_state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   grant;
    logic [WIDTH-1:0]  op_a, op_b;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic              res;
    logic              cmp_neq;

    // Scan downward so the candidate closest to p is written last and wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                                input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] cand;
        rr_pick = p;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = p + ID_W'(i);
            if (v[cand]) rr_pick = cand;
        end
    endfunction

    always_comb begin
        grant = rr_pick(req_valid, ptr);
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant] = 1'b1;
                    next_state       = COMPARE;
                end
            end
            COMPARE: next_state = RESPOND;
            RESPOND: if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr  <= '0;
            id   <= '0;
            op_a <= '0;
            op_b <= '0;
            res  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        op_a <= sel_a;
                        op_b <= sel_b;
                        id   <= grant;
                    end
                end
                COMPARE: res <= cmp_neq;
                RESPOND: if (rsp_ready) ptr <= id + ID_W'(1);
                default: ;
            endcase
        end
    end

    neq_cmp #(.WIDTH(WIDTH)) u_neq_cmp (
        .a   (op_a),
        .b   (op_b),
        .neq (cmp_neq)
    );

    assign rsp_valid = (state == RESPOND);
    assign rsp_id    = id;
    assign rsp_neq   = res;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter: transaction-level model checked every cycle plus directed scenarios.
module tb_cmp_share_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [19:0] req_a = '0;
    logic [19:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_neq;
    logic        rsp_ready = 1'b1;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit auto_drop = 0;

    int m_phase = 0;
    int m_ptr   = 0;
    int m_id    = 0;
    int m_res   = 0;
    int m_pend  = 0;
    bit m_fresh = 1;

    int rsp_ids[$];
    int rsp_neqs[$];
    int rsp_cyc[$];
    int gnt_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmp_share_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_neq   (rsp_neq),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Model: one transaction in flight, phases free / computing / holding result.
    always @(negedge clk) begin : compare
        logic [3:0] exp_rdy;
        int g;
        g = pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (m_phase == 0 && g >= 0) exp_rdy[g] = 1'b1;
        if (cyc >= 1) begin
            chk("req_ready", req_ready, exp_rdy);
            chk("rsp_valid", rsp_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            if (m_phase == 2 || m_fresh) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_neq", rsp_neq, m_res);
            end
        end
        if ((req_ready & req_valid) != 4'd0) gnt_cyc.push_back(cyc);
        if (rsp_valid && rsp_ready) begin
            rsp_ids.push_back(int'(rsp_id));
            rsp_neqs.push_back(int'(rsp_neq));
            rsp_cyc.push_back(cyc);
        end
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_id = 0; m_res = 0; m_fresh = 1;
        end else begin
            case (m_phase)
                0: if (g >= 0) begin
                    m_id    = g;
                    m_pend  = (req_a[g*5 +: 5] != req_b[g*5 +: 5]) ? 1 : 0;
                    m_phase = 1;
                    m_fresh = 0;
                end
                1: begin m_res = m_pend; m_phase = 2; end
                2: if (rsp_ready) begin m_ptr = (m_id + 1) % 4; m_phase = 0; end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic run_until(input int nrsp, input int budget, input string nm);
        logic [3:0] g;
        int k;
        k = 0;
        while (rsp_ids.size() < nrsp && k < budget) begin
            @(negedge clk);
            g = req_ready & req_valid;
            @(posedge clk);
            #2;
            if (auto_drop) req_valid = req_valid & ~g;
            k++;
        end
        chk({nm, " response count"}, rsp_ids.size(), nrsp);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        int base, gb, cset, cnt;
        int e_id[4];
        int e_neq[4];

        step(2);
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset rsp_neq", rsp_neq, 0);
        reset = 1'b0;

        // single request from requester 2, equal operands
        req_a[14:10] = 5'b10101;
        req_b[14:10] = 5'b10101;
        req_valid = 4'b0100;
        #1 chk("t1 req_ready", req_ready, 4'b0100);
        auto_drop = 1;
        base = rsp_ids.size();
        gb = gnt_cyc.size();
        run_until(base + 1, 10, "t1");
        if (rsp_ids.size() > base && gnt_cyc.size() > gb) begin
            chk("t1 rsp_id", rsp_ids[base], 2);
            chk("t1 rsp_neq", rsp_neqs[base], 0);
            chk("t1 latency", rsp_cyc[base] - gnt_cyc[gb], 2);
        end

        // all four valid at once
        reset_pulse();
        req_a = {5'b01100, 5'b00000, 5'b11010, 5'b11111};
        req_b = {5'b01100, 5'b00000, 5'b11011, 5'b00000};
        req_valid = 4'b1111;
        base = rsp_ids.size();
        run_until(base + 4, 30, "t2");
        e_id  = '{0, 1, 2, 3};
        e_neq = '{1, 1, 0, 0};
        if (rsp_ids.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t2 id[%0d]", k), rsp_ids[base + k], e_id[k]);
                chk($sformatf("t2 neq[%0d]", k), rsp_neqs[base + k], e_neq[k]);
                if (k > 0) chk($sformatf("t2 spacing[%0d]", k), rsp_cyc[base + k] - rsp_cyc[base + k - 1], 3);
            end
        end

        // fairness between requesters 0 and 3
        reset_pulse();
        auto_drop = 0;
        req_a = {5'b10000, 5'b00000, 5'b00000, 5'b00001};
        req_b = {5'b00000, 5'b00000, 5'b00000, 5'b00001};
        req_valid = 4'b1001;
        base = rsp_ids.size();
        run_until(base + 4, 30, "t3");
        req_valid = 4'b0000;
        e_id  = '{0, 3, 0, 3};
        e_neq = '{0, 1, 0, 1};
        if (rsp_ids.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t3 id[%0d]", k), rsp_ids[base + k], e_id[k]);
                chk($sformatf("t3 neq[%0d]", k), rsp_neqs[base + k], e_neq[k]);
            end
        end

        // backpressure on the response port
        rsp_ready = 1'b0;
        req_a[9:5] = 5'b00001;
        req_b[9:5] = 5'b00011;
        req_valid = 4'b0010;
        step(1);
        req_valid = 4'b0000;
        for (int k = 0; k < 10 && !rsp_valid; k++) step(1);
        chk("t4 rsp_valid reached", rsp_valid, 1);
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            chk("t4 stall rsp_valid", rsp_valid, 1);
            chk("t4 stall rsp_id", rsp_id, 1);
            chk("t4 stall rsp_neq", rsp_neq, 1);
            chk("t4 stall req_ready", req_ready, 0);
            step(1);
        end
        base = rsp_ids.size();
        rsp_ready = 1'b1;
        cset = cyc;
        step(1);
        chk("t4 release count", rsp_ids.size(), base + 1);
        if (rsp_ids.size() > base) chk("t4 release cycle", rsp_cyc[base], cset);
        auto_drop = 1;
        run_until(base + 2, 10, "t4 next");
        if (rsp_ids.size() >= base + 2) chk("t4 next id", rsp_ids[base + 1], 0);

        // reset while in COMPARE
        req_a[14:10] = 5'b11111;
        req_b[14:10] = 5'b00000;
        req_valid = 4'b0100;
        #1 chk("t5 req_ready", req_ready, 4'b0100);
        step(1);
        req_valid = 4'b0000;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t5 req_ready", req_ready, 0);
        chk("t5 rsp_valid", rsp_valid, 0);
        chk("t5 busy", busy, 0);
        chk("t5 rsp_id", rsp_id, 0);
        chk("t5 rsp_neq", rsp_neq, 0);
        base = rsp_ids.size();
        step(6);
        chk("t5 no response", rsp_ids.size(), base);
        req_valid = 4'b0011;
        #1 chk("t5 grant after reset", req_ready, 4'b0001);
        run_until(base + 1, 10, "t5a");
        if (rsp_ids.size() > base) chk("t5 first id", rsp_ids[base], 0);
        run_until(base + 2, 10, "t5b");
        if (rsp_ids.size() > base + 1) chk("t5 second id", rsp_ids[base + 1], 1);
        req_valid = 4'b0000;

        // withdrawn request
        reset_pulse();
        req_valid = 4'b0011;
        #1 chk("t6 req_ready", req_ready, 4'b0001);
        step(1);
        req_valid = 4'b0000;
        base = rsp_ids.size();
        step(8);
        chk("t6 response count", rsp_ids.size(), base + 1);
        cnt = 0;
        for (int k = base; k < rsp_ids.size(); k++)
            if (rsp_ids[k] == 1) cnt++;
        chk("t6 no id1 response", cnt, 0);
        if (rsp_ids.size() > base) chk("t6 id", rsp_ids[base], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cmp_share_arbiter.md
# cmp_share_arbiter

Round-robin arbiter and sequencer that shares one 5-bit inequality comparator among four requesters. Each requester offers an operand pair (a, b) through a valid/ready handshake. The block grants one requester at a time, registers the operands, and evaluates a != b with the shared comparator. It returns the one-bit result tagged with the requester ID through a valid/ready response port. It sits between the Guia_08 comparator datapath and any client blocks that need inequality tests.

## Interface
- N_REQ, 4, number of requesters; fixed at 4 in this revision; ID width 2
- WIDTH, 5, operand width in bits
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- req_valid  in  N_REQ  per-requester request strobe
- req_a  in  N_REQ*WIDTH  packed operand a; requester i uses bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  packed operand b; same packing as req_a
- req_ready  out  N_REQ  one-hot accept strobe; at most one bit high per cycle
- rsp_valid  out  1  response available
- rsp_id  out  2  index of the requester that owns the response
- rsp_neq  out  1  comparison result: 1 when a != b, 0 when a == b
- rsp_ready  in  1  consumer accepts the response
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, COMPARE, RESPOND.
- IDLE, no valid requests: req_ready = 0; state holds.
- IDLE, any req_valid high:
  - Winner g is the first requester with valid set, scanning from ptr upward with wrap (ptr, ptr+1, …, ptr+3 mod 4).
  - req_ready[g] = 1 combinationally in that cycle only. The handshake completes when req_valid[g] & req_ready[g].
  - Latch op_a, op_b and id = g on the edge; go to COMPARE.
- COMPARE: the shared comparator evaluates op_a vs op_b. Register res = OR of the bitwise XOR. Go to RESPOND.
- RESPOND: rsp_valid = 1, with rsp_id = id and rsp_neq = res. rsp_id and rsp_neq are held stable until rsp_valid & rsp_ready.
  - On that handshake: ptr ← (id + 1) mod 4; go to IDLE.
- req_ready is 0 in COMPARE and RESPOND. No request is accepted while a request is in flight.
- Requesters hold a, b stable while valid is high. A requester may drop valid before it is granted; no grant, no response.
- A request with valid high and no grant waits indefinitely. Round-robin guarantees a grant within 4 transactions.
- Width rule: result is 1 when any of the WIDTH bit positions differ, with no arithmetic. Operands are compared as raw bit vectors; X/Z handling is not specified.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, id = 0, op_a = op_b = 0, res = 0
  - rsp_valid = 0, rsp_id = 0, rsp_neq = 0, req_ready = 0, busy = 0
- Reset has priority over every transition, including mid-transaction in COMPARE or RESPOND. The in-flight request is discarded and no response is produced.
- Latency: acceptance on edge T (req_ready high in cycle T) → rsp_valid high in cycle T+2.
- Back-to-back throughput: with rsp_ready held high, one result every 3 cycles. The next req_ready can assert in the cycle after the response handshake.
- rsp_ready low stalls in RESPOND with no limit. All outputs stay stable and no new request is accepted.
- Simultaneous requests from all 4 requesters: grants go in order ptr, ptr+1, ptr+2, ptr+3.
- busy rises in the cycle after acceptance and falls in the cycle after the response handshake.

## Structure
- Shared package holds:
  - CMP_WIDTH = 5, NUM_REQ = 4, ID_W = 2
  - the FSM state encoding: IDLE = 2'd0, COMPARE = 2'd1, RESPOND = 2'd2
- One sub-module, neq_cmp: a combinational WIDTH-bit inequality (XOR per bit, OR-reduce). It is instantiated once and is the only comparison logic in the block.
- The round-robin priority pick is an in-module function and does not get its own module.

## Test plan
- Reset, then single request: requester 2 offers a=5'b10101, b=5'b10101 → req_ready[2] in the first cycle; rsp_valid 2 cycles later with rsp_id=2, rsp_neq=0.
- All four requesters valid after reset, with rsp_ready=1:
  - requester 0: 11111 vs 00000; requester 1: 11010 vs 11011; requester 2: 00000 vs 00000; requester 3: 01100 vs 01100
  - → responses in order id 0,1,2,3 with neq 1,1,0,0, spaced 3 cycles apart.
- Fairness: requesters 0 and 3 held valid continuously → grants alternate 0,3,0,3. Neither is granted twice in a row.
- Backpressure: rsp_ready=0 for 5 cycles during RESPOND → rsp_valid, rsp_id and rsp_neq stay stable and req_ready stays 0; the response completes on the cycle rsp_ready rises.
- Mid-operation reset: reset asserted in COMPARE for 1 cycle → all outputs read their reset values the next cycle and no response is produced. ptr = 0, so the next request from requester 1 with requester 0 also valid grants 0 first.
- Withdrawn request: requester 1 drops valid while requester 0 is being served → no response for id 1 ever appears.
